mips_mem_arbiter: RTL and testbench

//  Shares the single-port unified 1024x32 word memory between the IF stage (instruction fetch,

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mips_mem_arb_prio.sv | 48 ++++
 rtl/mips_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the mips32 unified-memory arbiter.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic {
        OwnD = 1'b0,
        OwnI = 1'b1
    } owner_e;

endpackage

// File: rtl/mips_mem_arb_prio.sv
// Data-first priority arbiter with a saturating starvation counter that forces
// a waiting fetch through after STARVE_MAX consecutive losses.
module mips_mem_arb_prio #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic i_valid,
    input  logic d_valid,
    input  logic arb_en,
    output logic grant_i,
    output logic grant_d
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            starved;

    assign starved = (cnt_q == CntW'(STARVE_MAX));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        cnt_d   = cnt_q;
        if (arb_en) begin
            if (i_valid && (starved || !d_valid)) begin
                grant_i = 1'b1;
            end else if (d_valid) begin
                grant_d = 1'b1;
            end
            if (grant_i) begin
                cnt_d = '0;
            end else if (grant_d && i_valid && !starved) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between the IF and MEM stages,
// one transaction in flight, with fetch flush/discard handling.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    owner_e            owner_q;
    logic              discard_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              i_resp_q, d_resp_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    logic grant_i, grant_d, arb_en, fetch_req, kill_fetch;

    // A flushed fetch must not be accepted, nor count as a lost arbitration.
    assign fetch_req  = i_valid & ~i_flush;
    assign arb_en     = (state_q == StIdle);
    assign kill_fetch = (owner_q == OwnI) & (discard_q | i_flush);

    mips_mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .i_valid (fetch_req),
        .d_valid (d_valid),
        .arb_en  (arb_en),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_ready      = grant_i;
    assign d_ready      = grant_d;
    assign mem_req      = (state_q == StIssue);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_resp_valid = i_resp_q;
    assign i_rdata      = i_rdata_q;
    assign d_resp_valid = d_resp_q;
    assign d_rdata      = d_rdata_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= OwnD;
            discard_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_i || grant_d) begin
                        state_q   <= StIssue;
                        owner_q   <= grant_i ? OwnI : OwnD;
                        addr_q    <= grant_i ? i_addr : d_addr;
                        we_q      <= grant_d & d_we;
                        wdata_q   <= grant_d ? d_wdata : '0;
                        discard_q <= 1'b0;
                    end
                end
                StIssue: begin
                    if (owner_q == OwnI && i_flush) begin
                        // Once granted the access can't be recalled; eat its response.
                        if (mem_gnt) begin
                            state_q   <= StWait;
                            discard_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (mem_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (owner_q == OwnI && i_flush) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state_q   <= StIdle;
                        discard_q <= 1'b0;
                        if (owner_q == OwnD) begin
                            d_resp_q  <= 1'b1;
                            d_rdata_q <= we_q ? '0 : mem_rdata;
                        end else if (!kill_fetch) begin
                            i_resp_q  <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter with a randomised-latency memory model.
module tb_mips_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready, i_flush, i_resp_valid;
    logic [9:0]  i_addr;
    logic [31:0] i_rdata;
    logic        d_valid, d_ready, d_we, d_resp_valid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mips_mem_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_addr       (i_addr),
        .i_flush      (i_flush),
        .i_resp_valid (i_resp_valid),
        .i_rdata      (i_rdata),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_resp_valid (d_resp_valid),
        .d_rdata      (d_rdata),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk1 = ~clk1;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model state
    logic [31:0] mem [1024];
    bit          hold_gnt = 1'b0;
    bit          fixed_lat = 1'b0;
    bit          stray = 1'b0;
    bit          rv_pend = 1'b0;
    logic [31:0] rv_data = '0;
    int          gnt_wait = -1;
    int unsigned gnt_cnt = 0;
    logic        last_we = 1'b0;
    logic [9:0]  last_addr = '0;

    // Scoreboard state
    logic [31:0] d_q[$];
    logic [31:0] i_q[$];
    int unsigned cyc = 0;
    int unsigned d_acc_cyc = 0;
    int unsigned d_lat = 0;
    int unsigned d_resp_cnt = 0;
    int unsigned i_resp_cnt = 0;

    initial forever begin
        @(posedge clk1);
        cyc++;
    end

    // Memory: gnt after 0-2 cycles of mem_req, rvalid the cycle after gnt.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk1);
            mem_rvalid = 1'b0;
            if (rv_pend || stray) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rv_data;
                rv_pend    = 1'b0;
                stray      = 1'b0;
            end
            mem_gnt = 1'b0;
            if (mem_req && !hold_gnt) begin
                if (gnt_wait < 0) gnt_wait = fixed_lat ? 0 : int'($urandom_range(0, 2));
                if (gnt_wait == 0) begin
                    mem_gnt   = 1'b1;
                    gnt_cnt++;
                    last_we   = mem_we;
                    last_addr = mem_addr;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        rv_data       = '0;
                    end else begin
                        rv_data = mem[mem_addr];
                    end
                    rv_pend  = 1'b1;
                    gnt_wait = -1;
                end else begin
                    gnt_wait--;
                end
            end else if (!mem_req) begin
                gnt_wait = -1;
            end
        end
    end

    // Response monitor
    initial forever begin
        @(negedge clk1);
        if (d_resp_valid) begin
            d_resp_cnt++;
            d_lat = cyc - d_acc_cyc;
            if (d_q.size() == 0) check("d_resp_unexpected", 1, 0);
            else check("d_rdata", d_rdata, d_q.pop_front());
        end
        if (i_resp_valid) begin
            i_resp_cnt++;
            if (i_q.size() == 0) check("i_resp_unexpected", 1, 0);
            else check("i_rdata", i_rdata, i_q.pop_front());
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b0;
        d_valid = 1'b0;
        repeat (2) @(negedge clk1);
        d_q.delete();
        i_q.delete();
        rst_n = 1'b1;
    endtask

    // Returns at the negedge after the accept edge (DUT in ISSUE).
    task automatic drive_d(input bit we, input logic [9:0] a, input logic [31:0] wd,
                           input logic [31:0] exp);
        bit done = 1'b0;
        @(negedge clk1);
        d_valid = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (d_ready) begin
                d_q.push_back(exp);
                d_acc_cyc = cyc;
                done      = 1'b1;
            end
            @(negedge clk1);
        end
        d_valid = 1'b0;
        if (!done) check("d_accept_timeout", 0, 1);
    endtask

    task automatic drive_i(input logic [9:0] a, input logic [31:0] exp, input bit push);
        bit done = 1'b0;
        @(negedge clk1);
        i_valid = 1'b1;
        i_addr  = a;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (i_ready) begin
                if (push) i_q.push_back(exp);
                done = 1'b1;
            end
            @(negedge clk1);
        end
        i_valid = 1'b0;
        if (!done) check("i_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        while ((d_q.size() != 0 || i_q.size() != 0) && k < 100) begin
            @(negedge clk1);
            k++;
        end
        if (k >= 100) check("drain_timeout", 0, 1);
        repeat (3) @(negedge clk1);
    endtask

    initial begin
        int unsigned g0, ir0, dr0, grants;
        bit          got_i;
        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        mem[5]  = 32'hDEADBEEF;
        mem[3]  = 32'h3333_0003;
        mem[20] = 32'h2020_0020;
        i_addr  = '0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        do_reset();
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_d_resp", d_resp_valid, 0);
        check("rst_i_rdata", i_rdata, 0);

        // 1: single LD, minimum latency
        fixed_lat = 1'b1;
        drive_d(1'b0, 10'd5, 32'h0, 32'hDEADBEEF);
        d_valid = 1'b1;
        #1;
        check("t1_d_ready_busy", d_ready, 0);
        d_valid = 1'b0;
        drain();
        check("t1_mem_we", last_we, 0);
        check("t1_mem_addr", last_addr, 10'd5);
        check("t1_latency", d_lat, 3);
        check("t1_no_i_resp", i_resp_cnt, 0);
        check("t1_d_resp_cnt", d_resp_cnt, 1);

        // 2: SD then fetch of same address
        fixed_lat = 1'b0;
        drive_d(1'b1, 10'd9, 32'h1234, 32'h0);
        drain();
        check("t2_sd_we", last_we, 1);
        check("t2_sd_addr", last_addr, 10'd9);
        drive_i(10'd9, 32'h1234, 1'b1);
        drain();
        check("t2_fetch_cnt", i_resp_cnt, 1);

        // 3: both requesters held, starvation order D,D,D,D,I repeating
        do_reset();
        @(negedge clk1);
        i_valid = 1'b1;
        i_addr  = 10'd1;
        d_valid = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'd2;
        grants  = 0;
        for (int k = 0; k < 300 && grants < 10; k++) begin
            #1;
            if (i_ready || d_ready) begin
                check("t3_one_ready", {31'd0, i_ready & d_ready}, 0);
                got_i = i_ready;
                if (got_i) i_q.push_back(mem[1]);
                else d_q.push_back(mem[2]);
                check("t3_grant_order", {31'd0, got_i}, (grants % 5 == 4) ? 1 : 0);
                grants++;
            end
            @(negedge clk1);
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        if (grants < 10) check("t3_grant_timeout", grants, 10);
        drain();

        // 4: i_flush blocks accept; flush in ISSUE without gnt aborts the fetch
        @(negedge clk1);
        i_valid = 1'b1;
        i_flush = 1'b1;
        #1;
        check("t4_flush_blocks_ready", i_ready, 0);
        i_valid = 1'b0;
        i_flush = 1'b0;
        hold_gnt = 1'b1;
        g0  = gnt_cnt;
        ir0 = i_resp_cnt;
        drive_i(10'd3, 32'h0, 1'b0);
        #1;
        check("t4_req_in_issue", mem_req, 1);
        i_flush = 1'b1;
        @(negedge clk1);
        i_flush = 1'b0;
        #1;
        check("t4_req_dropped", mem_req, 0);
        hold_gnt = 1'b0;
        repeat (5) @(negedge clk1);
        check("t4_no_grant", gnt_cnt, g0);
        check("t4_no_i_resp", i_resp_cnt, ir0);

        // 5: flush on the gnt cycle (v=0) and in WAIT (v=1); only addr 20 delivered
        for (int v = 0; v < 2; v++) begin
            bit seen = 1'b0;
            ir0 = i_resp_cnt;
            drive_i(10'd3, 32'h0, 1'b0);
            for (int k = 0; k < 20 && !seen; k++) begin
                #2;
                if (mem_gnt) seen = 1'b1;
                else @(negedge clk1);
            end
            if (!seen) check("t5_gnt_timeout", 0, 1);
            if (v == 1) @(negedge clk1);
            i_flush = 1'b1;
            @(negedge clk1);
            i_flush = 1'b0;
            drive_i(10'd20, 32'h2020_0020, 1'b1);
            drain();
            check("t5_single_resp", i_resp_cnt, ir0 + 1);
        end

        // 6: reset in WAIT, stray rvalid ignored, then a normal LD
        fixed_lat = 1'b1;
        drive_d(1'b0, 10'd5, 32'h0, 32'hDEADBEEF);
        @(negedge clk1);
        #1;
        rst_n = 1'b0;
        d_q.delete();
        #1;
        check("t6_rst_mem_req", mem_req, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_d_rdata", d_rdata, 0);
        check("t6_rst_d_resp", d_resp_valid, 0);
        dr0 = d_resp_cnt;
        @(negedge clk1);
        rst_n = 1'b1;
        stray = 1'b1;
        repeat (3) @(negedge clk1);
        check("t6_stray_ignored", d_resp_cnt, dr0);
        check("t6_idle_no_req", mem_req, 0);
        drive_d(1'b0, 10'd7, 32'h0, mem[7]);
        drain();
        check("t6_ld_done", d_resp_cnt, dr0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
